muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative integer multiply/divide unit for the EX stage of the 5-stage MIPS pipeline. It owns the HI/LO registers and executes MULT/MULTU/DIV/DIVU over multiple cycles. It is the stall-requesting counterpart of the hazard detection unit: it raises `HiLoStall` to freeze IF/ID while a HI/LO consumer waits, and it obeys that unit's `Flush_EX`.

## Interface
- `WIDTH`, 32, operand width; HI/LO are each `WIDTH` bits.
- `clk`  in  1  pipeline clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `Start_EX`  in  1  a mult/div instruction is in EX this cycle.
- `Op_EX`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `MtHi_EX`, `MtLo_EX`  in  1 each  MTHI/MTLO in EX; write `A_EX` to HI/LO.
- `Flush_EX`  in  1  the EX instruction is a bubble; suppresses `Start_EX`, `MtHi_EX` and `MtLo_EX`.
- `A_EX`, `B_EX`  in  `WIDTH`  rs/rt operands (dividend/divisor), already forwarded.
- `HiLoUse_ID`  in  1  the instruction in ID is MFHI/MFLO/MTHI/MTLO/MULT*/DIV*.
- `Hi`, `Lo`  out  `WIDTH`  architectural HI/LO, registered.
- `Busy`  out  1  an operation is in progress.
- `HiLoStall`  out  1  `Busy && HiLoUse_ID`; ORed into the stall/flush equations.
- `Done`  out  1  one-cycle pulse when HI/LO take a mult/div result.

## Operation
- FSM states: IDLE, CALC, FIX.
  - IDLE → CALC on `Start_EX && !Flush_EX`. Operands and op are captured. Signed ops latch the operand signs and convert the operands to magnitudes.
  - CALC runs exactly `WIDTH` iterations, driven by a count-down counter from `WIDTH-1` to 0.
    - Multiply uses shift-add on a 2·`WIDTH` accumulator.
    - Divide uses restoring shift-subtract, producing the remainder and quotient.
  - CALC → FIX when the counter reaches 0. FIX applies the sign correction and writes HI/LO, asserts `Done`, then returns to IDLE.
- Results:
  - MULT/MULTU: {HI, LO} = 2·`WIDTH`-bit product. For MULT, the product is negated when the operand signs differ.
  - DIV/DIVU: LO = quotient, HI = remainder. For DIV, the quotient is negated when the operand signs differ, and the remainder takes the dividend's sign.
  - Divide by zero, both DIV and DIVU: HI = dividend (unmodified `A_EX`), LO = all ones.
  - DIV of 0x80000000 by -1: LO = 0x80000000, HI = 0. The magnitude wraps and no trap is raised.
- MTHI/MTLO are single-cycle writes in IDLE. They are never seen while `Busy`, because `HiLoStall` holds them in ID.
- `Start_EX`, `MtHi_EX` or `MtLo_EX` arriving while `Busy` is a protocol violation. It is ignored and flagged by an assertion.
- `Flush_EX` does not abort an operation already in CALC/FIX: that operation belongs to an older, committed instruction.
- `Busy` = state != IDLE.
- `HiLoStall` and `Busy` are combinational from registered state, with no path from `A_EX`/`B_EX`.

## Timing
- Reset values: state IDLE, `Hi` = 0, `Lo` = 0, `Busy` = 0, `HiLoStall` = 0, `Done` = 0, counter = 0.
- Reset asserted mid-operation aborts immediately: HI/LO return to 0 and no `Done` is issued.
- Operation timeline, with start accepted at edge 0:
  - `Busy` is high for cycles 1..`WIDTH`+1.
  - HI/LO update at edge `WIDTH`+1.
  - `Done` is high in cycle `WIDTH`+1.
  - Total latency is 33 cycles for `WIDTH`=32.
- A HI/LO consumer held in ID by `HiLoStall` is released the cycle after FIX. It reads the new HI/LO in EX with no forwarding needed.
- MTHI/MTLO update `Hi`/`Lo` on the next edge.
- Simultaneous `MtHi_EX` and `MtLo_EX` writes both registers.
- Simultaneous `Start_EX` and `MtHi_EX`/`MtLo_EX` cannot occur; this is enforced by an assertion.

## Structure
- Shared package/header `mips_pkg`: `Op_EX` encodings (`OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`) and FSM state encodings. The hazard detection unit and decoder use the same op encodings.
- One natural sub-module, `muldiv_step`: combinational single iteration (add-shift or subtract-shift), instantiated once and selected by op. FSM, counter and HI/LO registers stay in the parent.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → after 33 cycles HI=0xFFFFFFFE, LO=0x00000001, `Done` pulses once, `Busy` low in cycle 34.
- MULT -3 × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1; DIV -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 7 / 0 → HI=0x00000007, LO=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- `Start_EX` with `Flush_EX`=1 → `Busy` stays 0, HI/LO unchanged. `HiLoUse_ID`=1 during an operation → `HiLoStall`=1 through FIX and 0 in the cycle after `Done`.
- Reset (`reset`=0) in cycle 10 of a DIV → `Busy`=0, HI=LO=0 immediately. No `Done` follows; the next MTLO 0x1234 sets LO=0x1234.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared op and FSM encodings for the multiply/divide unit, hazard unit and decoder.
package mips_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } md_state_t;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add for multiply, restoring shift-subtract for divide.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   acc_next
);

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   top;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    // Partial remainder shifted left by one; needs WIDTH+1 bits before the compare.
    top  = acc[2*WIDTH-1:WIDTH-1];
    ge   = (top >= {1'b0, operand});
    diff = top[WIDTH-1:0] - operand;
    if (is_div) begin
      acc_next = {(ge ? diff : top[WIDTH-1:0]), acc[WIDTH-2:0], ge};
    end else begin
      acc_next = {add_sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; stalls HI/LO consumers in ID while busy.
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start_EX,
  input  logic [1:0]       Op_EX,
  input  logic             MtHi_EX,
  input  logic             MtLo_EX,
  input  logic             Flush_EX,
  input  logic [WIDTH-1:0] A_EX,
  input  logic [WIDTH-1:0] B_EX,
  input  logic             HiLoUse_ID,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             HiLoStall,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH);

  md_state_t          state_reg, state_next;
  logic [CW-1:0]      count_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   operand_reg;
  logic [WIDTH-1:0]   dividend_reg;
  logic [WIDTH-1:0]   hi_reg, lo_reg;
  logic               is_div_reg, neg_q_reg, neg_r_reg, div_zero_reg;

  logic               start_ok, mt_hi_ok, mt_lo_ok, sgn;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;

  assign start_ok = (state_reg == ST_IDLE) && Start_EX && !Flush_EX;
  assign mt_hi_ok = (state_reg == ST_IDLE) && MtHi_EX && !Flush_EX;
  assign mt_lo_ok = (state_reg == ST_IDLE) && MtLo_EX && !Flush_EX;
  assign sgn      = op_is_signed(Op_EX);
  assign mag_a    = (sgn && A_EX[WIDTH-1]) ? -A_EX : A_EX;
  assign mag_b    = (sgn && B_EX[WIDTH-1]) ? -B_EX : B_EX;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div_reg),
    .acc      (acc_reg),
    .operand  (operand_reg),
    .acc_next (acc_step)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start_ok) state_next = ST_CALC;
      ST_CALC: if (count_reg == '0) state_next = ST_FIX;
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Sign fix-up; the negate flags are only ever set for signed ops.
  always_comb begin
    prod = neg_q_reg ? -acc_reg : acc_reg;
    quo  = neg_q_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    rem  = neg_r_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
    if (!is_div_reg) begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else if (div_zero_reg) begin
      res_hi = dividend_reg;
      res_lo = '1;
    end else begin
      res_hi = rem;
      res_lo = quo;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg    <= '0;
      acc_reg      <= '0;
      operand_reg  <= '0;
      dividend_reg <= '0;
      is_div_reg   <= 1'b0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start_ok) begin
            count_reg    <= CW'(WIDTH - 1);
            acc_reg      <= {{WIDTH{1'b0}}, mag_a};
            operand_reg  <= mag_b;
            dividend_reg <= A_EX;
            is_div_reg   <= op_is_div(Op_EX);
            neg_q_reg    <= sgn && (A_EX[WIDTH-1] ^ B_EX[WIDTH-1]);
            neg_r_reg    <= sgn && A_EX[WIDTH-1];
            div_zero_reg <= (B_EX == '0);
          end
          if (mt_hi_ok) hi_reg <= A_EX;
          if (mt_lo_ok) lo_reg <= A_EX;
        end
        ST_CALC: begin
          acc_reg <= acc_step;
          if (count_reg != '0) count_reg <= count_reg - 1'b1;
        end
        ST_FIX: begin
          hi_reg <= res_hi;
          lo_reg <= res_lo;
        end
        default: ;
      endcase
    end
  end

  assign Busy      = (state_reg != ST_IDLE);
  assign HiLoStall = Busy && HiLoUse_ID;
  assign Done      = (state_reg == ST_FIX);
  assign Hi        = hi_reg;
  assign Lo        = lo_reg;

  // Protocol: no new request while busy, and no start together with MTHI/MTLO.
  a_no_start_busy: assert property (@(posedge clk) disable iff (!reset)
    Busy |-> !((Start_EX || MtHi_EX || MtLo_EX) && !Flush_EX));
  a_no_start_mt: assert property (@(posedge clk) disable iff (!reset)
    !(Start_EX && (MtHi_EX || MtLo_EX) && !Flush_EX));

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench: randomized ops against an arithmetic reference of HI/LO and timing.
module tb_muldiv_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          Start_EX = 1'b0, MtHi_EX = 1'b0, MtLo_EX = 1'b0, Flush_EX = 1'b0;
  logic [1:0]    Op_EX = 2'b00;
  logic [W-1:0]  A_EX = '0, B_EX = '0;
  logic          HiLoUse_ID = 1'b0;
  logic [W-1:0]  Hi, Lo;
  logic          Busy, HiLoStall, Done;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [W-1:0]  m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int            m_busy = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .Start_EX   (Start_EX),
    .Op_EX      (Op_EX),
    .MtHi_EX    (MtHi_EX),
    .MtLo_EX    (MtLo_EX),
    .Flush_EX   (Flush_EX),
    .A_EX       (A_EX),
    .B_EX       (B_EX),
    .HiLoUse_ID (HiLoUse_ID),
    .Hi         (Hi),
    .Lo         (Lo),
    .Busy       (Busy),
    .HiLoStall  (HiLoStall),
    .Done       (Done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference result {HI, LO} from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: res = 64'(sa * sb);
      2'b01: res = {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 0) res = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) res = {a, 32'hFFFFFFFF};
        else res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  // Cycle model: a start occupies the unit for W+1 cycles, results land at the last edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi <= '0;
      m_lo <= '0;
      m_busy <= 0;
    end else if (m_busy > 0) begin
      m_busy <= m_busy - 1;
      if (m_busy == 1) begin
        m_hi <= p_hi;
        m_lo <= p_lo;
      end
    end else if (!Flush_EX) begin
      if (Start_EX) begin
        {p_hi, p_lo} <= ref_result(Op_EX, A_EX, B_EX);
        m_busy <= W + 1;
      end else begin
        if (MtHi_EX) m_hi <= A_EX;
        if (MtLo_EX) m_lo <= A_EX;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("hi", 64'(Hi), 64'(m_hi));
      chk("lo", 64'(Lo), 64'(m_lo));
      chk("busy", 64'(Busy), 64'(m_busy != 0));
      chk("done", 64'(Done), 64'(m_busy == 1));
      chk("stall", 64'(HiLoStall), 64'((m_busy != 0) && HiLoUse_ID));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit hold_use);
    int waited;
    int done_cnt;
    Start_EX = 1'b1; Op_EX = op; A_EX = a; B_EX = b; Flush_EX = 1'b0;
    HiLoUse_ID = hold_use ? 1'b1 : 1'($urandom_range(0, 1));
    step();
    Start_EX = 1'b0; A_EX = $urandom; B_EX = $urandom;
    waited = 0;
    done_cnt = 0;
    while (Busy && waited < 40) begin
      if (Done) done_cnt++;
      if (!hold_use) HiLoUse_ID = 1'($urandom_range(0, 1));
      step();
      waited++;
    end
    chk("latency", 64'(waited), 64'(W + 1));
    chk("done_pulses", 64'(done_cnt), 64'd1);
    HiLoUse_ID = 1'b0;
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h", op, a, b, Hi, Lo);
  endtask

  task automatic mt(input bit hi_en, input bit lo_en, input logic [31:0] val);
    MtHi_EX = hi_en; MtLo_EX = lo_en; A_EX = val;
    step();
    MtHi_EX = 1'b0; MtLo_EX = 1'b0;
    $display("mt hi=%0d lo=%0d val=%h -> hi=%h lo=%h", hi_en, lo_en, val, Hi, Lo);
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] saved_hi, saved_lo;
    #3 reset = 1'b0;
    chk_en = 1'b1;
    repeat (3) step();
    reset = 1'b1;
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_hi", 64'(Hi), 64'd0);
    chk("rst_lo", 64'(Lo), 64'd0);

    chk("model_multu", ref_result(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF), 64'hFFFFFFFE_00000001);
    chk("model_mult", ref_result(2'b00, 32'hFFFFFFFD, 32'd5), 64'hFFFFFFFF_FFFFFFF1);
    chk("model_div", ref_result(2'b10, 32'hFFFFFFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);
    chk("model_divu0", ref_result(2'b11, 32'd7, 32'd0), 64'h00000007_FFFFFFFF);
    chk("model_divovf", ref_result(2'b10, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);

    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    chk("multu_hi", 64'(Hi), 64'hFFFFFFFE);
    chk("multu_lo", 64'(Lo), 64'h00000001);
    chk("multu_busy_after", 64'(Busy), 64'd0);
    run_op(2'b00, 32'hFFFFFFFD, 32'd5, 1'b1);
    chk("mult_hi", 64'(Hi), 64'hFFFFFFFF);
    chk("mult_lo", 64'(Lo), 64'hFFFFFFF1);
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0);
    chk("div_hi", 64'(Hi), 64'hFFFFFFFF);
    chk("div_lo", 64'(Lo), 64'hFFFFFFFD);
    run_op(2'b11, 32'd7, 32'd0, 1'b0);
    chk("divu0_hi", 64'(Hi), 64'h00000007);
    chk("divu0_lo", 64'(Lo), 64'hFFFFFFFF);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    chk("divovf_hi", 64'(Hi), 64'h0);
    chk("divovf_lo", 64'(Lo), 64'h80000000);

    // Flushed start must not begin an operation.
    mt(1'b1, 1'b1, 32'hA5A5_0001);
    saved_hi = Hi;
    saved_lo = Lo;
    Start_EX = 1'b1; Flush_EX = 1'b1; Op_EX = 2'b10; A_EX = 32'd100; B_EX = 32'd3;
    step();
    Start_EX = 1'b0; Flush_EX = 1'b0;
    chk("flush_busy", 64'(Busy), 64'd0);
    step();
    chk("flush_hi", 64'(Hi), 64'(saved_hi));
    chk("flush_lo", 64'(Lo), 64'(saved_lo));

    // Reset during a divide aborts it with no Done.
    mt(1'b1, 1'b0, 32'h0000_0055);
    Start_EX = 1'b1; Op_EX = 2'b10; A_EX = 32'd1000; B_EX = 32'd7;
    step();
    Start_EX = 1'b0;
    repeat (9) step();
    reset = 1'b0;
    #1;
    chk("abort_busy", 64'(Busy), 64'd0);
    chk("abort_hi", 64'(Hi), 64'd0);
    chk("abort_lo", 64'(Lo), 64'd0);
    step();
    reset = 1'b1;
    repeat (40) step();
    mt(1'b0, 1'b1, 32'h0000_1234);
    chk("mtlo_after_abort", 64'(Lo), 64'h1234);

    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 6))
        0, 1, 2, 3: run_op(2'($urandom_range(0, 3)), rand_opnd(), rand_opnd(), 1'b0);
        4: mt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
        5: begin
          Start_EX = 1'b1; Flush_EX = 1'b1; Op_EX = 2'($urandom_range(0, 3));
          A_EX = $urandom; B_EX = $urandom;
          step();
          Start_EX = 1'b0; Flush_EX = 1'b0;
          $display("flushed start -> busy=%0d", Busy);
        end
        default: begin
          HiLoUse_ID = 1'($urandom_range(0, 1));
          step();
          HiLoUse_ID = 1'b0;
        end
      endcase
    end

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
